param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal value; q counts 0..MAX; MAX SHALL be <= 2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1, enabled cycles per count step (1..65535).
REQ-004 Parameter SATURATE, default 0, 0 = wrap at boundary, 1 = hold at boundary.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 clr  input  1  synchronous clear of q and prescaler.
REQ-008 load  input  1  synchronous load of q from d.
REQ-009 d  input  WIDTH  load value.
REQ-010 en  input  1  count enable.
REQ-011 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-012 q  output  WIDTH  registered count.
REQ-013 tc  output  1  registered terminal-count pulse.

Function
REQ-014 Priority per edge SHALL be clr > load > count step; lower-priority actions are ignored that cycle.
REQ-015 clr=1: q <= 0, prescaler <= 0, tc <= 0.
REQ-016 load=1: q <= d when d <= MAX, else q <= MAX; prescaler <= 0; tc <= 0.
REQ-017 Prescaler: internal counter 0..PRESCALE-1, advances only when en=1, holds when en=0; a step occurs when en=1 and prescaler = PRESCALE-1, and the prescaler then returns to 0.
REQ-018 PRESCALE=1: a step occurs on every cycle with en=1.
REQ-019 A step with up=1 SHALL set q <= q+1 when q < MAX; with up=0 it SHALL set q <= q-1 when q > 0.
REQ-020 A step at the boundary (up=1, q=MAX, or up=0, q=0) with SATURATE=0 SHALL wrap q to 0 (up) or MAX (down).
REQ-021 A step at the boundary with SATURATE=1 SHALL hold q unchanged.
REQ-022 tc SHALL be 1 for exactly the one cycle following each boundary step, coincident with the wrapped or held q; 0 otherwise.
REQ-023 Changing up mid-prescale SHALL NOT reset the prescaler; the next step uses up as sampled on that edge.
REQ-024 Arithmetic SHALL be modulo-free beyond REQ-019..021; q SHALL never exceed MAX.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, set q=0, tc=0, prescaler=0 and, if compiled in, cap_q=0.
REQ-026 Reset asserted mid-prescale or mid-step SHALL discard the pending step; the first step after release occurs after PRESCALE enabled cycles.

Configuration
REQ-027 Macro PARAM_COUNTER_CAPTURE_EN defined: add input cap (1 bit) and output cap_q (WIDTH bits); on an edge with cap=1, cap_q <= q as it was before that edge, independent of clr/load/en.
REQ-028 Macro undefined: ports cap and cap_q SHALL be absent; all other behaviour identical.

Verification
REQ-029 Defaults, en=1, up=1, 20 cycles after reset -> q 0,1..15,0,1,2,3; tc=1 only in the cycle q returns to 0.
REQ-030 PRESCALE=3, MAX=9, en=1, up=0 from q=0 -> q 0,0,0,9,9,9,8; tc=1 with the first q=9 only.
REQ-031 SATURATE=1, MAX=5, load d=4, en=1, up=1 -> q 4,5,5,5; tc=1 in each cycle after a held step at q=5.
REQ-032 clr=1, load=1, d=7 with en=1 in the same cycle -> q=0, tc=0; load alone with d=12, MAX=9 -> q=9.
REQ-033 rst pulsed asynchronously between edges at q=6 -> q=0 before the next edge; with PRESCALE=4, first step occurs 4 enabled cycles after release.
REQ-034 PARAM_COUNTER_CAPTURE_EN defined, cap=1 on the edge where q goes 7->8 -> cap_q=7; macro undefined -> design elaborates without cap/cap_q.

Source files
------------

// File: rtl/param_counter.sv
// param_counter: parameterised up/down counter with enable prescaler,
// wrap or saturate at the count boundary, and a one-cycle terminal-count
// pulse. Priority per edge is clr > load > count step.
// Optional feature: define PARAM_COUNTER_CAPTURE_EN to add the cap input
// and the cap_q output. On an edge with cap=1, cap_q takes the value q had
// before that edge.
module param_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
`ifdef PARAM_COUNTER_CAPTURE_EN
    input  logic             cap,
    output logic [WIDTH-1:0] cap_q,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V   = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
    // The prescaler is 16 bits wide because PRESCALE is at most 65535,
    // so its count never exceeds 65534.
    localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [15:0]      pre_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic             tc_nxt_s;
    logic [15:0]      pre_nxt_s;
    logic             pre_last_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] step_q_s;
    logic [WIDTH-1:0] load_q_s;

    // Next-state logic: prescaler advance, step value, clr/load priority.
    always_comb begin
        q_nxt_s    = q_r;
        tc_nxt_s   = 1'b0;
        pre_nxt_s  = pre_r;
        pre_last_s = (pre_r == PRE_LAST);
        at_bound_s = up ? (q_r == MAX_V) : (q_r == ZERO_V);
        step_q_s   = q_r;
        load_q_s   = (d > MAX_V) ? MAX_V : d;

        // Value q would take if a step happened this edge.
        if (up) begin
            if (at_bound_s) begin
                step_q_s = SATURATE ? q_r : ZERO_V;
            end else begin
                step_q_s = q_r + ONE_V;
            end
        end else begin
            if (at_bound_s) begin
                step_q_s = SATURATE ? q_r : MAX_V;
            end else begin
                step_q_s = q_r - ONE_V;
            end
        end

        if (clr) begin
            q_nxt_s   = ZERO_V;
            pre_nxt_s = 16'd0;
            tc_nxt_s  = 1'b0;
        end else if (load) begin
            q_nxt_s   = load_q_s;
            pre_nxt_s = 16'd0;
            tc_nxt_s  = 1'b0;
        end else if (en) begin
            if (pre_last_s) begin
                pre_nxt_s = 16'd0;
                q_nxt_s   = step_q_s;
                tc_nxt_s  = at_bound_s;
            end else begin
                pre_nxt_s = pre_r + 16'd1;
                q_nxt_s   = q_r;
                tc_nxt_s  = 1'b0;
            end
        end else begin
            pre_nxt_s = pre_r;
            q_nxt_s   = q_r;
            tc_nxt_s  = 1'b0;
        end
    end

    // State registers: count, prescaler and terminal-count pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= ZERO_V;
            tc_r  <= 1'b0;
            pre_r <= 16'd0;
        end else begin
            q_r   <= q_nxt_s;
            tc_r  <= tc_nxt_s;
            pre_r <= pre_nxt_s;
        end
    end

    assign q  = q_r;
    assign tc = tc_r;

`ifdef PARAM_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q_r;

    // Snapshot of the pre-edge count, unaffected by clr, load and en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q_r <= ZERO_V;
        end else if (cap) begin
            cap_q_r <= q_r;
        end else begin
            cap_q_r <= cap_q_r;
        end
    end

    assign cap_q = cap_q_r;
`endif

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter. Four instances with different
// parameters: u0 defaults, u1 MAX=9 PRESCALE=3, u2 MAX=5 SATURATE=1,
// u3 PRESCALE=4. Expected values are pushed to a scoreboard queue before
// each edge and are compared after the edge.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_a  [4];
    logic       load_a [4];
    logic       en_a   [4];
    logic       up_a   [4];
    logic [3:0] d_a    [4];
    logic [3:0] q_a    [4];
    logic       tc_a   [4];
`ifdef PARAM_COUNTER_CAPTURE_EN
    logic       cap_a   [4];
    logic [3:0] cap_q_a [4];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        param_counter #(
            .WIDTH    (4),
            .MAX      ((g == 1) ? 9 : ((g == 2) ? 5 : 15)),
            .PRESCALE ((g == 1) ? 3 : ((g == 3) ? 4 : 1)),
            .SATURATE (g == 2)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_a[g]),
            .load  (load_a[g]),
            .d     (d_a[g]),
            .en    (en_a[g]),
            .up    (up_a[g]),
`ifdef PARAM_COUNTER_CAPTURE_EN
            .cap   (cap_a[g]),
            .cap_q (cap_q_a[g]),
`endif
            .q     (q_a[g]),
            .tc    (tc_a[g])
        );
    end

    typedef struct {
        int inst;
        int q;
        int tc;
        int cap;
    } exp_t;

    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_q   [4];
    int   m_pre [4];
    int   m_tc  [4];
    int   m_cap [4];

    function automatic int cfg_max(input int i);
        return (i == 1) ? 9 : ((i == 2) ? 5 : 15);
    endfunction

    function automatic int cfg_pre(input int i);
        return (i == 1) ? 3 : ((i == 3) ? 4 : 1);
    endfunction

    function automatic bit cfg_sat(input int i);
        return (i == 2);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            m_q[i]   = 0;
            m_pre[i] = 0;
            m_tc[i]  = 0;
            m_cap[i] = 0;
        end
    endtask

    // Behavioural reference for one clock edge of instance i.
    task automatic model_edge(input int i);
        int mx;
        int q_old;
        mx    = cfg_max(i);
        q_old = m_q[i];
`ifdef PARAM_COUNTER_CAPTURE_EN
        if (cap_a[i]) m_cap[i] = q_old;
`endif
        m_tc[i] = 0;
        if (clr_a[i]) begin
            m_q[i]   = 0;
            m_pre[i] = 0;
        end else if (load_a[i]) begin
            m_q[i]   = (int'(d_a[i]) > mx) ? mx : int'(d_a[i]);
            m_pre[i] = 0;
        end else if (en_a[i]) begin
            if (m_pre[i] == cfg_pre(i) - 1) begin
                m_pre[i] = 0;
                if (up_a[i]) begin
                    if (q_old == mx) begin
                        m_tc[i] = 1;
                        if (!cfg_sat(i)) m_q[i] = 0;
                    end else begin
                        m_q[i] = q_old + 1;
                    end
                end else begin
                    if (q_old == 0) begin
                        m_tc[i] = 1;
                        if (!cfg_sat(i)) m_q[i] = mx;
                    end else begin
                        m_q[i] = q_old - 1;
                    end
                end
            end else begin
                m_pre[i] = m_pre[i] + 1;
            end
        end
    endtask

    // One clock: predict, push, wait for the edge, pop and compare.
    task automatic tick();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            model_edge(i);
            e.inst = i;
            e.q    = m_q[i];
            e.tc   = m_tc[i];
            e.cap  = m_cap[i];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("u%0d q", e.inst), {28'd0, q_a[e.inst]}, e.q);
            check_val($sformatf("u%0d tc", e.inst), {31'd0, tc_a[e.inst]}, e.tc);
`ifdef PARAM_COUNTER_CAPTURE_EN
            check_val($sformatf("u%0d cap_q", e.inst), {28'd0, cap_q_a[e.inst]}, e.cap);
`endif
        end
    endtask

    task automatic set_in(input int i, input bit c, input bit l, input int dv, input bit e, input bit u);
        clr_a[i]  = c;
        load_a[i] = l;
        d_a[i]    = 4'(dv);
        en_a[i]   = e;
        up_a[i]   = u;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            set_in(i, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`ifdef PARAM_COUNTER_CAPTURE_EN
            cap_a[i] = 1'b0;
`endif
        end
    endtask

    initial begin
        int exp_u1 [6];
        int exp_u2 [4];
        exp_u1 = '{0, 0, 9, 9, 9, 8};
        exp_u2 = '{4, 5, 5, 5};

        idle_all();
        rst = 1'b1;
        reset_model();
        #12;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("reset u%0d q", i), {28'd0, q_a[i]}, 0);
            check_val($sformatf("reset u%0d tc", i), {31'd0, tc_a[i]}, 0);
        end
        rst = 1'b0;

        // Free run: u0 up, u1 down, u2 load 4 then up into saturation, u3 up.
        for (int k = 0; k < 20; k++) begin
            set_in(0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
            set_in(1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
            set_in(2, 1'b0, (k == 0), 4, 1'b1, 1'b1);
            set_in(3, 1'b0, 1'b0, 0, 1'b1, 1'b1);
            tick();
            check_val("wrap seq q", {28'd0, q_a[0]}, (k + 1) % 16);
            check_val("wrap seq tc", {31'd0, tc_a[0]}, (k == 15) ? 1 : 0);
            if (k < 6) begin
                check_val("down prescale q", {28'd0, q_a[1]}, exp_u1[k]);
                check_val("down prescale tc", {31'd0, tc_a[1]}, (k == 2) ? 1 : 0);
            end
            if (k < 4) begin
                check_val("saturate q", {28'd0, q_a[2]}, exp_u2[k]);
                check_val("saturate tc", {31'd0, tc_a[2]}, (k >= 2) ? 1 : 0);
            end
        end
        idle_all();

        // clr beats load and count; load above MAX clamps.
        set_in(1, 1'b1, 1'b1, 7, 1'b1, 1'b1);
        tick();
        check_val("clr priority q", {28'd0, q_a[1]}, 0);
        check_val("clr priority tc", {31'd0, tc_a[1]}, 0);
        set_in(1, 1'b0, 1'b1, 12, 1'b0, 1'b1);
        set_in(0, 1'b0, 1'b1, 12, 1'b0, 1'b1);
        tick();
        check_val("load clamp q", {28'd0, q_a[1]}, 9);
        check_val("load in range q", {28'd0, q_a[0]}, 12);
        idle_all();

        // Capture of the pre-edge count on the 7 -> 8 step.
        set_in(0, 1'b0, 1'b1, 7, 1'b0, 1'b1);
        tick();
        set_in(0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
`ifdef PARAM_COUNTER_CAPTURE_EN
        cap_a[0] = 1'b1;
`endif
        tick();
        check_val("capture step q", {28'd0, q_a[0]}, 8);
`ifdef PARAM_COUNTER_CAPTURE_EN
        check_val("capture cap_q", {28'd0, cap_q_a[0]}, 7);
`endif
        idle_all();

        // Async reset between edges with u0 at 6 and u3 mid-prescale.
        set_in(0, 1'b0, 1'b1, 6, 1'b0, 1'b1);
        set_in(3, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        set_in(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        check_val("pre-reset q", {28'd0, q_a[0]}, 6);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("async reset u%0d q", i), {28'd0, q_a[i]}, 0);
            check_val($sformatf("async reset u%0d tc", i), {31'd0, tc_a[i]}, 0);
        end
        reset_model();
        #2;
        rst = 1'b0;
        idle_all();
        set_in(3, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("post-reset prescale q", {28'd0, q_a[3]}, (k == 3) ? 1 : 0);
        end
        idle_all();

        // Random traffic, including direction changes mid-prescale.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                set_in(i, ($urandom_range(0, 24) == 0), ($urandom_range(0, 19) == 0),
                       int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) != 0));
`ifdef PARAM_COUNTER_CAPTURE_EN
                cap_a[i] = ($urandom_range(0, 3) == 0);
`endif
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
